// File: rtl/mux_scan_pkg.sv
// ---------------------------------------------------------------------------
// mux_scan_pkg
//   Shared types and constants for the 16:1 mux scan sequencer.
//   - scan_state_t : FSM state encoding (idle / settle / capture / done)
//   - DEF_SELW     : default select width (16 channels)
//   - DEF_SETTLE   : default settle wait in cycles
//   - SETTLE_CW    : width of the settle down-counter (settle range 0..15)
//   State names carry an ST_ prefix because SETTLE is also a module parameter.
// ---------------------------------------------------------------------------
package mux_scan_pkg;

  localparam int DEF_SELW   = 4;
  localparam int DEF_SETTLE = 1;
  localparam int SETTLE_CW  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } scan_state_t;

endpackage

// File: rtl/mux_scan_settle_cnt.sv
// ---------------------------------------------------------------------------
// mux_scan_settle_cnt
//   Loadable down-counter with a zero flag, used to time the settle wait
//   after each mux select change. It stops at zero rather than wrapping.
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   load   in   load 'value' into the counter this cycle
//   value  in   reload value (SETTLE_CW bits)
//   zero   out  counter currently equals zero
// ---------------------------------------------------------------------------
module mux_scan_settle_cnt
  import mux_scan_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [SETTLE_CW-1:0] value,
  output logic                 zero
);

  logic [SETTLE_CW-1:0] r_cnt;

  // Load has priority; otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - SETTLE_CW'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// ---------------------------------------------------------------------------
// mux_scan_ctrl
//   Sequencer upstream of a 2**SELW : 1 channel mux. Steps the mux select
//   through a programmable (possibly wrapping) channel range, waits SETTLE
//   cycles after each select change, then captures mux_out into sample[ch].
//   Reports busy while scanning and a one-cycle done pulse per pass.
// Parameters:
//   SELW    select width, NCH = 2**SELW channels
//   SETTLE  wait cycles after each select change before capture (0..15)
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   begin scan (only honoured in idle)
//   abort     in   stop scan, wins over start
//   first_ch  in   first channel of range, sampled with start
//   last_ch   in   last channel of range, sampled with start
//   mux_out   in   mux data bit for the current select
//   select    out  registered mux select
//   busy      out  scan in progress
//   done      out  one-cycle pulse at the end of each pass
//   sample    out  captured bits, sample[ch] = mux_out seen for channel ch
// Configuration macro:
//   CONTINUOUS_SCAN_EN - when defined the scan restarts at the latched first
//   channel after every pass, keeping busy high and updating sample in place
//   until abort or reset. When undefined each start runs a single pass.
// ---------------------------------------------------------------------------
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SELW   = DEF_SELW,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [SELW-1:0]       first_ch,
  input  logic [SELW-1:0]       last_ch,
  input  logic                  mux_out,
  output logic [SELW-1:0]       select,
  output logic                  busy,
  output logic                  done,
  output logic [(2**SELW)-1:0]  sample
);

  localparam int NCH = 2**SELW;

  // Counter reload so the settle state lasts exactly SETTLE cycles.
  localparam logic [SETTLE_CW-1:0] SETTLE_LOAD =
    (SETTLE == 0) ? '0 : SETTLE_CW'(SETTLE - 1);

  // With no settle time a select change goes straight to capture.
  localparam scan_state_t AFTER_SELECT = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;

  scan_state_t     r_state;
  logic [SELW-1:0] r_select;
  logic [SELW-1:0] r_lastCh;
`ifdef CONTINUOUS_SCAN_EN
  logic [SELW-1:0] r_firstCh;
`endif
  logic            r_busy;
  logic            r_done;
  logic [NCH-1:0]  r_sample;

  logic            w_cntLoad;
  logic            w_cntZero;

  // The counter is held at its reload value in every state except settle,
  // so it always holds SETTLE-1 on entry to settle.
  assign w_cntLoad = (r_state != ST_SETTLE);

  mux_scan_settle_cnt u_settleCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_cntLoad),
    .value (SETTLE_LOAD),
    .zero  (w_cntZero)
  );

  // Scan FSM with registered outputs. Abort outside idle overrides every
  // state transition and leaves select and already captured bits untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_select <= '0;
      r_lastCh <= '0;
`ifdef CONTINUOUS_SCAN_EN
      r_firstCh <= '0;
`endif
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sample <= '0;
    end else begin
      r_done <= 1'b0;
      if (abort && (r_state != ST_IDLE)) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && !abort) begin
              r_lastCh <= last_ch;
`ifdef CONTINUOUS_SCAN_EN
              r_firstCh <= first_ch;
`endif
              r_select <= first_ch;
              r_sample <= '0;
              r_busy   <= 1'b1;
              r_state  <= AFTER_SELECT;
            end
          end
          ST_SETTLE: begin
            if (w_cntZero) begin
              r_state <= ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            r_sample[r_select] <= mux_out;
            if (r_select == r_lastCh) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
`ifndef CONTINUOUS_SCAN_EN
              r_busy  <= 1'b0;
`endif
            end else begin
              // Natural wrap of the SELW-bit select gives the modulo-NCH step.
              r_select <= r_select + SELW'(1);
              r_state  <= AFTER_SELECT;
            end
          end
          ST_DONE: begin
`ifdef CONTINUOUS_SCAN_EN
            r_select <= r_firstCh;
            r_state  <= AFTER_SELECT;
`else
            r_state  <= ST_IDLE;
`endif
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign select = r_select;
  assign busy   = r_busy;
  assign done   = r_done;
  assign sample = r_sample;

endmodule
